// File: rtl/alu_sched_pkg.sv
// ---------------------------------------------------------------------------
// alu_sched_pkg
// Shared definitions for the ALU scheduler: ALU op codes, status flag bit
// positions (status layout ---SVNZC), scheduler FSM states, the status reset
// default and the captured-transaction record.
// ---------------------------------------------------------------------------
package alu_sched_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_TRA = 2'd2,
        ALU_TRB = 2'd3
    } alu_op_e;

    // Status flag bit positions.
    localparam int CF = 0;
    localparam int ZF = 1;
    localparam int NF = 2;
    localparam int VF = 3;
    localparam int SF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [7:0] ST_RST_DEFAULT = 8'h00;

    // Operation captured from the granted requester.
    typedef struct packed {
        alu_op_e    op;
        logic [7:0] a;
        logic [7:0] b;
        logic       wst;
        logic       id;
    } xact_t;

endpackage

// File: rtl/alu_sched_if.sv
// ---------------------------------------------------------------------------
// alu_sched_if
// Request/response bus between the two ALU requesters (plus the response
// consumer) and the scheduler.
//   reqN_valid/op/a/b/wst : requester N operation, held until reqN_ready
//   reqN_ready            : one-cycle accept pulse from the scheduler
//   rsp_valid/id/r/st     : registered response, held until rsp_ready
//   rsp_ready             : response consumer accepts
// master = requester/consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface alu_sched_if;
    import alu_sched_pkg::*;

    logic       req0_valid;
    logic       req0_ready;
    alu_op_e    req0_op;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req0_wst;

    logic       req1_valid;
    logic       req1_ready;
    alu_op_e    req1_op;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       req1_wst;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_r;
    logic [7:0] rsp_st;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_wst,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_wst,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_r, rsp_st,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_wst,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_wst,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_r, rsp_st,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter (purely combinational).
//   valid[1:0]  : request lines
//   last_grant  : id granted most recently
//   grant[1:0]  : one-hot grant, zero when nobody requests
//   grant_id    : index of the granted requester
// A lone requester always wins; on contention the one that did not win
// last time is chosen.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    assign grant_id = (valid == 2'b11) ? ~last_grant : valid[1];
    assign grant    = (valid == 2'b00) ? 2'b00
                    : (grant_id ? 2'b10 : 2'b01);

endmodule

// File: rtl/alu_sched.sv
// ---------------------------------------------------------------------------
// alu_sched
// Shares one external combinational ALU between the CPU execute stage
// (requester 0) and the address/index unit (requester 1). Each operation
// runs IDLE (accept) -> EXEC (ALU evaluates) -> RESP (result held until
// taken). The block owns the status register and feeds it to the ALU.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus               : request/response bus (slave side)
//   st                : current status register
//   st_ld, st_din     : external status load, wins over an ALU commit
//   alu_a/b/op        : ALU operand and op drive, held outside EXEC
//   alu_st_in         : ALU status input, always equals st
//   alu_r, alu_st_out : ALU result and status output
// ---------------------------------------------------------------------------
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter logic [7:0] ST_RST = ST_RST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_sched_if.slave  bus,
    output logic [7:0]  st,
    input  logic        st_ld,
    input  logic [7:0]  st_din,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_st_in,
    input  logic [7:0]  alu_r,
    input  logic [7:0]  alu_st_out
);

    state_e     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    xact_t      xact_q, xact_d;
    logic [7:0] rsp_r_q, rsp_r_d;
    logic [7:0] rsp_st_q, rsp_st_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] st_q, st_d;

    logic [1:0] req_valid;
    logic [1:0] grant;
    logic       grant_id;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        xact_d         = xact_q;
        rsp_r_d        = rsp_r_q;
        rsp_st_d       = rsp_st_q;
        rsp_id_d       = rsp_id_q;
        st_d           = st_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    bus.req0_ready = grant[0];
                    bus.req1_ready = grant[1];
                    last_grant_d   = grant_id;
                    xact_d = grant_id
                        ? '{op: bus.req1_op, a: bus.req1_a, b: bus.req1_b,
                            wst: bus.req1_wst, id: 1'b1}
                        : '{op: bus.req0_op, a: bus.req0_a, b: bus.req0_b,
                            wst: bus.req0_wst, id: 1'b0};
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_r_d  = alu_r;
                rsp_st_d = alu_st_out;
                rsp_id_d = xact_q.id;
                if (xact_q.wst) begin
                    st_d = alu_st_out;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // External load overrides any ALU status commit in the same cycle;
        // rsp_st still reports what the ALU produced.
        if (st_ld) begin
            st_d = st_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;   // requester 0 wins the first contention
            xact_q       <= '0;
            rsp_r_q      <= '0;
            rsp_st_q     <= '0;
            rsp_id_q     <= 1'b0;
            st_q         <= ST_RST;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            xact_q       <= xact_d;
            rsp_r_q      <= rsp_r_d;
            rsp_st_q     <= rsp_st_d;
            rsp_id_q     <= rsp_id_d;
            st_q         <= st_d;
        end
    end

    // The ALU is driven straight from the captured operation: it changes only
    // when a new operation is accepted, so it is stable through EXEC.
    assign alu_a     = xact_q.a;
    assign alu_b     = xact_q.b;
    assign alu_op    = xact_q.op;
    assign alu_st_in = st_q;
    assign st        = st_q;

    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_r     = rsp_r_q;
    assign bus.rsp_st    = rsp_st_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_sched
// Directed bench for alu_sched with a behavioural model of the external ALU
// (status ---SVNZC; C is carry for ADD, borrow for SUB; TRA/TRB pass st_in).
// ---------------------------------------------------------------------------
module tb_alu_sched;
    import alu_sched_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] st;
    logic       st_ld;
    logic [7:0] st_din;
    logic [7:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_st_in;
    logic [7:0] alu_r;
    logic [7:0] alu_st_out;

    int n_vec;
    int n_err;

    alu_sched_if bus ();

    alu_sched #(.ST_RST(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .st         (st),
        .st_ld      (st_ld),
        .st_din     (st_din),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_st_in  (alu_st_in),
        .alu_r      (alu_r),
        .alu_st_out (alu_st_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model.
    logic [8:0] m_ext;
    logic       m_v;
    always_comb begin
        m_ext      = 9'h000;
        m_v        = 1'b0;
        alu_r      = 8'h00;
        alu_st_out = alu_st_in;
        case (alu_op)
            2'd0: begin
                m_ext = {1'b0, alu_a} + {1'b0, alu_b};
                m_v   = (alu_a[7] == alu_b[7]) && (m_ext[7] != alu_a[7]);
            end
            2'd1: begin
                m_ext = {1'b0, alu_a} - {1'b0, alu_b};
                m_v   = (alu_a[7] != alu_b[7]) && (m_ext[7] != alu_a[7]);
            end
            default: ;
        endcase
        case (alu_op)
            2'd0, 2'd1: begin
                alu_r      = m_ext[7:0];
                alu_st_out = {3'b000, m_ext[7] ^ m_v, m_v, m_ext[7],
                              (m_ext[7:0] == 8'h00), m_ext[8]};
            end
            2'd2: alu_r = alu_a;
            default: alu_r = alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input alu_op_e op, input logic [7:0] a, input logic [7:0] b, input logic wst);
        bus.req0_valid = 1'b1;
        bus.req0_op    = op;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_wst   = wst;
    endtask

    task automatic drive1(input alu_op_e op, input logic [7:0] a, input logic [7:0] b, input logic wst);
        bus.req1_valid = 1'b1;
        bus.req1_op    = op;
        bus.req1_a     = a;
        bus.req1_b     = b;
        bus.req1_wst   = wst;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        st_ld = 1'b0;
        st_din = 8'h00;
        bus.req0_valid = 1'b0; bus.req0_op = ALU_ADD; bus.req0_a = '0; bus.req0_b = '0; bus.req0_wst = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_op = ALU_ADD; bus.req1_a = '0; bus.req1_b = '0; bus.req1_wst = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        #3;
        chk("rst_ready0", {7'd0, bus.req0_ready}, 8'h00);
        chk("rst_ready1", {7'd0, bus.req1_ready}, 8'h00);
        chk("rst_rsp_valid", {7'd0, bus.rsp_valid}, 8'h00);
        chk("rst_rsp_r", bus.rsp_r, 8'h00);
        chk("rst_rsp_st", bus.rsp_st, 8'h00);
        chk("rst_rsp_id", {7'd0, bus.rsp_id}, 8'h00);
        chk("rst_st", st, 8'h00);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_op", {6'd0, alu_op}, 8'h00);
        #9 rst_n = 1'b1;
        tick();

        // req0 ADD 7F+01 with commit.
        drive0(ALU_ADD, 8'h7F, 8'h01, 1'b1);
        #1;
        chk("t1_ready0", {7'd0, bus.req0_ready}, 8'h01);
        chk("t1_ready1", {7'd0, bus.req1_ready}, 8'h00);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t1_exec_ready0", {7'd0, bus.req0_ready}, 8'h00);
        chk("t1_exec_rsp_valid", {7'd0, bus.rsp_valid}, 8'h00);
        chk("t1_alu_a", alu_a, 8'h7F);
        chk("t1_alu_b", alu_b, 8'h01);
        chk("t1_alu_op", {6'd0, alu_op}, 8'h00);
        tick();
        chk("t1_rsp_valid", {7'd0, bus.rsp_valid}, 8'h01);
        chk("t1_rsp_r", bus.rsp_r, 8'h80);
        chk("t1_rsp_st", bus.rsp_st, 8'h0C);
        chk("t1_st", st, 8'h0C);
        chk("t1_rsp_id", {7'd0, bus.rsp_id}, 8'h00);
        bus.rsp_ready = 1'b1;
        tick();
        chk("t1_done_rsp_valid", {7'd0, bus.rsp_valid}, 8'h00);

        // req1 SUB 05-05 with commit, then TRA 33 with commit.
        drive1(ALU_SUB, 8'h05, 8'h05, 1'b1);
        #1;
        chk("t2_ready1", {7'd0, bus.req1_ready}, 8'h01);
        chk("t2_ready0", {7'd0, bus.req0_ready}, 8'h00);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        chk("t2_rsp_r", bus.rsp_r, 8'h00);
        chk("t2_rsp_st", bus.rsp_st, 8'h02);
        chk("t2_st", st, 8'h02);
        chk("t2_rsp_id", {7'd0, bus.rsp_id}, 8'h01);
        tick();
        drive1(ALU_TRA, 8'h33, 8'h00, 1'b1);
        #1;
        chk("t2b_ready1", {7'd0, bus.req1_ready}, 8'h01);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        chk("t2b_rsp_r", bus.rsp_r, 8'h33);
        chk("t2b_rsp_st", bus.rsp_st, 8'h02);
        chk("t2b_st", st, 8'h02);
        tick();

        // Both requesters valid continuously: grants alternate 0,1,0,1.
        drive0(ALU_ADD, 8'hFF, 8'h01, 1'b1);
        drive1(ALU_TRB, 8'h00, 8'hAA, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_ready0", {7'd0, bus.req0_ready}, (i % 2 == 0) ? 8'h01 : 8'h00);
            chk("t3_ready1", {7'd0, bus.req1_ready}, (i % 2 == 1) ? 8'h01 : 8'h00);
            tick();
            chk("t3_exec_ready0", {7'd0, bus.req0_ready}, 8'h00);
            chk("t3_exec_ready1", {7'd0, bus.req1_ready}, 8'h00);
            tick();
            chk("t3_rsp_id", {7'd0, bus.rsp_id}, (i % 2 == 1) ? 8'h01 : 8'h00);
            chk("t3_rsp_r", bus.rsp_r, (i % 2 == 1) ? 8'hAA : 8'h00);
            chk("t3_st", st, 8'h03);
            tick();
        end

        // Backpressure: req0 ADD 10+20 (no commit) held 5 cycles in RESP.
        drive0(ALU_ADD, 8'h10, 8'h20, 1'b0);
        bus.rsp_ready = 1'b0;
        #1;
        chk("t4_ready0", {7'd0, bus.req0_ready}, 8'h01);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_rsp_valid", {7'd0, bus.rsp_valid}, 8'h01);
            chk("t4_rsp_r", bus.rsp_r, 8'h30);
            chk("t4_rsp_st", bus.rsp_st, 8'h00);
            chk("t4_ready0", {7'd0, bus.req0_ready}, 8'h00);
            chk("t4_ready1", {7'd0, bus.req1_ready}, 8'h00);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("t4_next_ready1", {7'd0, bus.req1_ready}, 8'h01);
        chk("t4_next_ready0", {7'd0, bus.req0_ready}, 8'h00);
        bus.req0_valid = 1'b0;
        tick();
        bus.req1_valid = 1'b0;
        tick();
        chk("t4_rsp_id", {7'd0, bus.rsp_id}, 8'h01);
        chk("t4_rsp_r2", bus.rsp_r, 8'hAA);
        chk("t4_st", st, 8'h03);
        tick();

        // st_ld during EXEC of a committing ADD wins over the ALU status.
        drive0(ALU_ADD, 8'h7F, 8'h01, 1'b1);
        #1;
        chk("t5_ready0", {7'd0, bus.req0_ready}, 8'h01);
        tick();
        bus.req0_valid = 1'b0;
        st_ld = 1'b1;
        st_din = 8'h10;
        tick();
        st_ld = 1'b0;
        chk("t5_st", st, 8'h10);
        chk("t5_rsp_st", bus.rsp_st, 8'h0C);
        chk("t5_rsp_r", bus.rsp_r, 8'h80);
        tick();
        st_ld = 1'b1;
        st_din = 8'h5A;
        tick();
        st_ld = 1'b0;
        chk("t5_idle_st_ld", st, 8'h5A);

        // Reset during EXEC; afterwards req0 wins the first contention.
        drive0(ALU_ADD, 8'h01, 8'h01, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid", {7'd0, bus.rsp_valid}, 8'h00);
        chk("t6_st", st, 8'h00);
        chk("t6_alu_a", alu_a, 8'h00);
        #2 rst_n = 1'b1;
        tick();
        chk("t6_idle_rsp_valid", {7'd0, bus.rsp_valid}, 8'h00);
        drive0(ALU_TRA, 8'h44, 8'h00, 1'b0);
        drive1(ALU_TRB, 8'h00, 8'h66, 1'b0);
        #1;
        chk("t6_ready0", {7'd0, bus.req0_ready}, 8'h01);
        chk("t6_ready1", {7'd0, bus.req1_ready}, 8'h00);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk("t6_rsp_id", {7'd0, bus.rsp_id}, 8'h00);
        chk("t6_rsp_r", bus.rsp_r, 8'h44);
        chk("t6_st_after", st, 8'h00);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
Scheduler that shares the single combinational ALU between two requesters: requester 0 is the CPU execute stage, requester 1 is the address/index unit.
- Arbitrates round-robin and sequences each operation over a fixed multi-cycle transaction.
- Owns the architectural status register (---SVNZC) and feeds it to the ALU as st_in.
- Returns a registered result and status to the granted requester through a valid/ready handshake.

Parameters:
ST_RST, 8'h00, status register value after reset.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operands accepted (one-cycle pulse)
req0_op  in  2  ALU operation code (ALU_ADD/SUB/TRA/TRB)
req0_a  in  8  operand a
req0_b  in  8  operand b
req0_wst  in  1  1 = commit ALU status to status register
req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_wst  same as requester 0, for requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  response consumer accepts result
rsp_id  out  1  requester that owns the response
rsp_r  out  8  registered ALU result
rsp_st  out  8  registered ALU status output for this operation
st  out  8  current status register
st_ld  in  1  external status register load (e.g. restore on return from interrupt)
st_din  in  8  value for st_ld
alu_a, alu_b  out  8  to ALU data inputs
alu_op  out  2  to ALU op selector
alu_st_in  out  8  to ALU status input; always equals st
alu_r  in  8  from ALU result
alu_st_out  in  8  from ALU status output

Behaviour:
- Reset is asynchronous on rst_n low:
  - FSM returns to IDLE; st = ST_RST; last_grant = 1, so requester 0 wins first.
  - All ready and valid outputs are 0; rsp_r, rsp_st, rsp_id, alu_a, alu_b, alu_op are 0.
  - An in-flight transaction is discarded. A status commit counts only if its clock edge completed before reset asserted.
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester and capture op, a, b, wst and the grant id into internal registers.
  - Pulse reqN_ready for that cycle only, then go to EXEC.
  - Arbitration: a lone valid requester wins. If both are valid, the one not equal to last_grant wins; last_grant updates on every grant.
  - reqN_ready is never high while the block is in EXEC or RESP.
- EXEC:
  - Drive alu_a, alu_b, alu_op from the captured registers. These outputs hold their values outside EXEC.
  - At the clock edge, register rsp_r = alu_r and rsp_st = alu_st_out, and set rsp_id.
  - If wst = 1, also load st = alu_st_out. For ALU_TRA/TRB the ALU passes st_in through, so st is unchanged in value.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_r, rsp_st and rsp_id are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE. The next grant occurs in that IDLE cycle at the earliest.
- Timing: operands are accepted in cycle T, rsp_valid rises at T+2, and the minimum issue interval is 3 cycles.
- st_ld:
  - Loads st = st_din in any state.
  - If st_ld coincides with an EXEC commit (wst = 1), st_ld wins and the ALU status is dropped. rsp_st still reports the ALU status.
- A requester must hold valid, op, a, b and wst stable until it sees ready. Deasserting valid before ready simply withdraws the request, with no error.
- An op outside the four codes cannot occur (2-bit field). Every result is 8-bit and wraps modulo 256; carry out is reported only through C.

Decomposition:
- Shared globals header (already holds the ALU op codes ALU_ADD/SUB/TRA/TRB and flag indices CF/ZF/NF/VF/SF) gains:
  - FSM state encodings S_IDLE, S_EXEC, S_RESP;
  - the ST_RST default.
- One sub-module is natural: rr_arb2, the two-way round-robin arbiter (inputs: valids, last_grant; outputs: grant, grant_id), so it can be reused by the memory port.
- The ALU itself stays external and is instantiated beside this block at the datapath level.

Test Plan:
- Reset then req0 ADD a=7F b=01 wst=1 -> req0_ready pulses, rsp_valid 2 cycles later, rsp_r=80, rsp_st=0C, st=0C, rsp_id=0.
- req1 SUB a=05 b=05 wst=1, rsp_ready held high -> rsp_r=00, st=02; a follow-up TRA a=33 wst=1 -> rsp_r=33, st stays 02.
- req0 and req1 both valid continuously (ADD FF+01 and TRB b=AA) -> grants alternate 0,1,0,1; req0 results r=00 st=03; req1 results r=AA.
- Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_r stable, both ready outputs stay 0, no second grant until the handshake completes.
- st_ld=1 st_din=10 in the same cycle as EXEC of ADD 7F+01 wst=1 -> st=10, rsp_st=0C.
- rst_n low during EXEC -> rsp_valid=0, st=ST_RST immediately; after release, req0 is granted first.
